// File: rtl/itcm_arbiter.sv
// Arbiter sharing the dual-half 64-bit ITCM SRAM between fetch, load/store and an external port.
// Define ITCM_EXT_PORT_EN to let the external loader/debug port take part in arbitration.
module itcm_arbiter #(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          cpurst,
    input  logic          if_req,
    input  logic [28:0]   if_adr,
    output logic          if_gnt,
    output logic [63:0]   if_rdata,
    output logic          if_rvalid,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [31:0]   ls_addr,
    input  logic [3:0]    ls_ben,
    input  logic [31:0]   ls_wdata,
    output logic          ls_gnt,
    output logic [31:0]   ls_rdata,
    output logic          ls_rvalid,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [31:0]   ext_addr,
    input  logic [3:0]    ext_ben,
    input  logic [31:0]   ext_wdata,
    output logic          ext_gnt,
    output logic [31:0]   ext_rdata,
    output logic          ext_rvalid,
    output logic          sram_csn0,
    output logic          sram_csn1,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_ben,
    output logic [63:0]   sram_din,
    input  logic [63:0]   sram_dout
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS, OWN_EXT} owner_t;

    logic [3:0] starve_cnt_reg;
    owner_t     owner_reg;
    logic       half_reg;
    logic       if_win, ls_win, ext_win, ext_act;
    logic       unused_bits;

`ifdef ITCM_EXT_PORT_EN
    assign ext_act = ext_req;
`else
    assign ext_act = 1'b0;
`endif

    // Address bits outside the SRAM window, and the EXT inputs when the port is compiled out.
    assign unused_bits = ^{if_adr, ls_addr, ext_req, ext_we, ext_addr, ext_ben, ext_wdata, ext_win};

    always_comb begin
        if_win  = 1'b0;
        ls_win  = 1'b0;
        ext_win = 1'b0;
        if (!cpurst) begin
            if (if_req && (starve_cnt_reg == STARVE_LIM)) if_win = 1'b1;
            else if (ls_req)                              ls_win = 1'b1;
            else if (ext_act)                             ext_win = 1'b1;
            else if (if_req)                              if_win = 1'b1;
        end
    end

    // A 32-bit access enables only the half picked by addr[2]; write data is mirrored to both.
    always_comb begin
        sram_csn0 = 1'b1;
        sram_csn1 = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = '0;
        sram_ben  = '0;
        sram_din  = '0;
        if (if_win) begin
            sram_csn0 = 1'b0;
            sram_csn1 = 1'b0;
            sram_addr = if_adr[AW-1:0];
            sram_ben  = 8'hFF;
        end else if (ls_win) begin
            sram_csn0 = ls_addr[2];
            sram_csn1 = ~ls_addr[2];
            sram_wen  = ~ls_we;
            sram_addr = ls_addr[AW+2:3];
            sram_ben  = ls_addr[2] ? {ls_ben, 4'b0} : {4'b0, ls_ben};
            sram_din  = {ls_wdata, ls_wdata};
        end
`ifdef ITCM_EXT_PORT_EN
        else if (ext_win) begin
            sram_csn0 = ext_addr[2];
            sram_csn1 = ~ext_addr[2];
            sram_wen  = ~ext_we;
            sram_addr = ext_addr[AW+2:3];
            sram_ben  = ext_addr[2] ? {ext_ben, 4'b0} : {4'b0, ext_ben};
            sram_din  = {ext_wdata, ext_wdata};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            starve_cnt_reg <= '0;
            owner_reg      <= OWN_NONE;
            half_reg       <= 1'b0;
        end else begin
            if (if_req && !if_win) begin
                if (starve_cnt_reg != STARVE_LIM) starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end else begin
                starve_cnt_reg <= '0;
            end
            // Writes leave owner at NONE so no read-valid strobe follows them.
            if (if_win) begin
                owner_reg <= OWN_IF;
            end else if (ls_win && !ls_we) begin
                owner_reg <= OWN_LS;
                half_reg  <= ls_addr[2];
            end else if (ext_win && !ext_we) begin
                owner_reg <= OWN_EXT;
                half_reg  <= ext_addr[2];
            end else begin
                owner_reg <= OWN_NONE;
            end
        end
    end

    assign if_gnt    = if_win;
    assign if_rdata  = sram_dout;
    assign if_rvalid = (owner_reg == OWN_IF) && !cpurst;
    assign ls_gnt    = ls_win;
    assign ls_rdata  = half_reg ? sram_dout[63:32] : sram_dout[31:0];
    assign ls_rvalid = (owner_reg == OWN_LS) && !cpurst;

`ifdef ITCM_EXT_PORT_EN
    assign ext_gnt    = ext_win;
    assign ext_rdata  = half_reg ? sram_dout[63:32] : sram_dout[31:0];
    assign ext_rvalid = (owner_reg == OWN_EXT) && !cpurst;
`else
    assign ext_gnt    = 1'b0;
    assign ext_rdata  = 32'h0;
    assign ext_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_itcm_arbiter.sv
// Bench for itcm_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_itcm_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int W_NONE = 0, W_IF = 1, W_LS = 2, W_EXT = 3;
`ifdef ITCM_EXT_PORT_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        cpurst;
    logic        if_req, ls_req, ls_we, ext_req, ext_we;
    logic [28:0] if_adr;
    logic [31:0] ls_addr, ls_wdata, ext_addr, ext_wdata;
    logic [3:0]  ls_ben, ext_ben;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ext_gnt, ext_rvalid;
    logic [63:0] if_rdata;
    logic [31:0] ls_rdata, ext_rdata;
    logic        sram_csn0, sram_csn1, sram_wen;
    logic [15:0] sram_addr;
    logic [7:0]  sram_ben;
    logic [63:0] sram_din, sram_dout;

    int checks = 0;
    int errors = 0;
    int m_starve = 0;
    int m_pend = W_NONE;
    logic m_half = 1'b0;

    itcm_arbiter #(.AW(16), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .cpurst(cpurst),
        .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_ben(ls_ben), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_ben(ext_ben), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .sram_csn0(sram_csn0), .sram_csn1(sram_csn1), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_ben(sram_ben), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Winner this cycle according to the arbitration rules.
    function automatic int exp_win();
        if (cpurst) return W_NONE;
        if (if_req && m_starve >= STARVE_MAX) return W_IF;
        if (ls_req) return W_LS;
        if (EXT_EN && ext_req) return W_EXT;
        if (if_req) return W_IF;
        return W_NONE;
    endfunction

    // Advance the model across the coming posedge, then move to the next negedge.
    task automatic tick();
        int w;
        w = exp_win();
        if (cpurst) begin
            m_starve = 0;
            m_pend   = W_NONE;
        end else begin
            if (if_req && w != W_IF) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else m_starve = 0;
            m_pend = W_NONE;
            if (w == W_IF) m_pend = W_IF;
            else if (w == W_LS && !ls_we) begin m_pend = W_LS; m_half = ls_addr[2]; end
            else if (w == W_EXT && !ext_we) begin m_pend = W_EXT; m_half = ext_addr[2]; end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; ls_req = 0; ls_we = 0; ext_req = 0; ext_we = 0;
        if_adr = '0; ls_addr = '0; ls_wdata = '0; ls_ben = '0;
        ext_addr = '0; ext_wdata = '0; ext_ben = '0; sram_dout = '0;
    endtask

    task automatic test_reset();
        cpurst = 1; if_req = 1; ls_req = 1; ext_req = 1; ls_addr = 32'h10; ext_addr = 32'h20; #1;
        checks++; if ({if_gnt, ls_gnt, ext_gnt, sram_csn0, sram_csn1} !== 5'b00011) begin
            errors++; $display("FAIL reset_gnt_csn: got %b want 00011", {if_gnt, ls_gnt, ext_gnt, sram_csn0, sram_csn1}); end
        tick();
        cpurst = 0; ls_req = 0; ext_req = 0; if_adr = 29'h40; #1;
        checks++; if ({if_gnt, if_rvalid, ls_rvalid, ext_rvalid} !== 4'b1000) begin
            errors++; $display("FAIL reset_first_fetch: got %b want 1000", {if_gnt, if_rvalid, ls_rvalid, ext_rvalid}); end
        checks++; if ({sram_csn0, sram_csn1, sram_wen, sram_ben, sram_addr} !== {3'b001, 8'hFF, 16'h0040}) begin
            errors++; $display("FAIL reset_fetch_sram: got %b%b%b %h %h want 001 ff 0040", sram_csn0, sram_csn1, sram_wen, sram_ben, sram_addr); end
        tick();
        if_req = 0; sram_dout = 64'h11223344_55667788; #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 64'h11223344_55667788) begin
            errors++; $display("FAIL reset_fetch_data: got v=%b d=%h want v=1 d=1122334455667788", if_rvalid, if_rdata); end
        tick();
    endtask

    task automatic test_ls_write();
        idle_inputs();
        ls_req = 1; ls_we = 1; ls_addr = 32'h0000_0104; ls_ben = 4'hF; ls_wdata = 32'hDEADBEEF; #1;
        checks++; if ({ls_gnt, sram_csn1, sram_csn0, sram_wen} !== 4'b1010) begin
            errors++; $display("FAIL ls_write_ctl: got %b want 1010", {ls_gnt, sram_csn1, sram_csn0, sram_wen}); end
        checks++; if (sram_ben !== 8'hF0 || sram_addr !== 16'h0020 || sram_din !== 64'hDEADBEEF_DEADBEEF) begin
            errors++; $display("FAIL ls_write_data: got ben=%h addr=%h din=%h want f0 0020 deadbeefdeadbeef", sram_ben, sram_addr, sram_din); end
        tick();
        ls_req = 0; ls_we = 0; #1;
        checks++; if (ls_rvalid !== 1'b0) begin
            errors++; $display("FAIL ls_write_no_rvalid: got %b want 0", ls_rvalid); end
        tick();
    endtask

    task automatic test_conflict();
        idle_inputs();
        if_req = 1; ls_req = 1; ls_addr = 32'h10; if_adr = 29'h7; #1;
        checks++; if ({ls_gnt, if_gnt} !== 2'b10) begin
            errors++; $display("FAIL conflict_ls_wins: got ls=%b if=%b want 1 0", ls_gnt, if_gnt); end
        tick();
        ls_req = 0; sram_dout = 64'hCAFEF00D_0BADBEEF; #1;
        checks++; if (if_gnt !== 1'b1 || ls_rvalid !== 1'b1 || ls_rdata !== 32'h0BADBEEF) begin
            errors++; $display("FAIL conflict_if_next: got gnt=%b rv=%b rd=%h want 1 1 0badbeef", if_gnt, ls_rvalid, ls_rdata); end
        tick();
        if_req = 0; #1;
        checks++; if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0) begin
            errors++; $display("FAIL conflict_if_rvalid: got if=%b ls=%b want 1 0", if_rvalid, ls_rvalid); end
        tick();
    endtask

    task automatic test_starvation();
        idle_inputs(); #1; tick();
        if_req = 1; ls_req = 1; ls_we = 1; ls_addr = 32'h8;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (if_gnt !== (i == 4 || i == 9) || ls_gnt !== !(i == 4 || i == 9)) begin
                errors++; $display("FAIL starve_cycle%0d: got if=%b ls=%b want if=%b", i, if_gnt, ls_gnt, (i == 4 || i == 9)); end
            tick();
        end
        idle_inputs(); #1; tick();
    endtask

    task automatic test_ext_read();
        idle_inputs();
        ext_req = 1; ext_we = 0; ext_addr = 32'h0000_0008; #1;
        checks++; if ({ext_gnt, sram_csn0, sram_csn1} !== (EXT_EN ? 3'b101 : 3'b011)) begin
            errors++; $display("FAIL ext_grant: got %b want %b", {ext_gnt, sram_csn0, sram_csn1}, (EXT_EN ? 3'b101 : 3'b011)); end
        tick();
        ext_req = 0; sram_dout = {32'hAAAA0000, 32'h5555FFFF}; #1;
        checks++; if (ext_rvalid !== EXT_EN || ext_rdata !== (EXT_EN ? 32'h5555FFFF : 32'h0)) begin
            errors++; $display("FAIL ext_rdata: got v=%b d=%h want v=%b", ext_rvalid, ext_rdata, EXT_EN); end
        tick();
        // LS keeps priority over EXT indefinitely.
        ls_req = 1; ls_we = 1; ext_req = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if ({ls_gnt, ext_gnt} !== 2'b10) begin
                errors++; $display("FAIL ext_waits%0d: got ls=%b ext=%b want 1 0", i, ls_gnt, ext_gnt); end
            tick();
        end
        idle_inputs(); #1; tick();
    endtask

    task automatic test_reset_mid_read();
        idle_inputs();
        if_req = 1; ls_req = 1; ls_we = 1;
        #1; tick(); #1; tick();
        ls_we = 0; ls_addr = 32'h4; #1;
        checks++; if (ls_gnt !== 1'b1) begin
            errors++; $display("FAIL midread_grant: got %b want 1", ls_gnt); end
        tick();
        cpurst = 1; ls_req = 0; #1;
        checks++; if ({ls_rvalid, ls_gnt, if_gnt, sram_csn0, sram_csn1} !== 5'b00011) begin
            errors++; $display("FAIL midread_in_reset: got %b want 00011", {ls_rvalid, ls_gnt, if_gnt, sram_csn0, sram_csn1}); end
        tick();
        cpurst = 0; ls_req = 1; ls_we = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (ls_rvalid !== 1'b0 || if_gnt !== (i == 4)) begin
                errors++; $display("FAIL midread_after%0d: got rv=%b if=%b want 0 %b", i, ls_rvalid, if_gnt, (i == 4)); end
            tick();
        end
        idle_inputs(); #1; tick();
    endtask

    task automatic test_random();
        int   w;
        logic hold_if;
        logic e_csn0, e_csn1, e_wen;
        logic [15:0] e_addr;
        logic [7:0]  e_ben;
        logic [63:0] e_din;
        logic [31:0] a, d;
        logic [3:0]  b;
        logic        we;
        hold_if = 0;
        for (int n = 0; n < 400; n++) begin
            cpurst  = ($urandom_range(0, 39) == 0);
            if_req  = hold_if ? 1'b1 : 1'($urandom_range(0, 1));
            if_adr  = 29'($urandom);
            ls_req  = ($urandom_range(0, 2) == 0);
            ls_we   = 1'($urandom);
            ls_addr = $urandom; ls_ben = 4'($urandom); ls_wdata = $urandom;
            ext_req = 1'($urandom);
            ext_we  = 1'($urandom);
            ext_addr = $urandom; ext_ben = 4'($urandom); ext_wdata = $urandom;
            sram_dout = {$urandom, $urandom};
            #1;
            w = exp_win();
            e_csn0 = 1; e_csn1 = 1; e_wen = 1; e_addr = '0; e_ben = '0; e_din = '0;
            if (w == W_IF) begin
                e_csn0 = 0; e_csn1 = 0; e_addr = 16'(if_adr); e_ben = 8'hFF;
            end else if (w == W_LS || w == W_EXT) begin
                a  = (w == W_LS) ? ls_addr : ext_addr;
                d  = (w == W_LS) ? ls_wdata : ext_wdata;
                b  = (w == W_LS) ? ls_ben : ext_ben;
                we = (w == W_LS) ? ls_we : ext_we;
                e_csn0 = a[2]; e_csn1 = !a[2]; e_wen = !we;
                e_addr = 16'((a >> 3) & 32'hFFFF);
                e_ben  = a[2] ? {b, 4'h0} : {4'h0, b};
                e_din  = {d, d};
            end
            checks++; if ({if_gnt, ls_gnt, ext_gnt} !== {w == W_IF, w == W_LS, w == W_EXT}) begin
                errors++; $display("FAIL rand%0d_gnt: got %b want %b", n, {if_gnt, ls_gnt, ext_gnt}, {w == W_IF, w == W_LS, w == W_EXT}); end
            checks++; if ({sram_csn0, sram_csn1, sram_wen, sram_addr, sram_ben, sram_din} !== {e_csn0, e_csn1, e_wen, e_addr, e_ben, e_din}) begin
                errors++; $display("FAIL rand%0d_sram: got %b%b%b %h %h %h want %b%b%b %h %h %h", n, sram_csn0, sram_csn1, sram_wen,
                    sram_addr, sram_ben, sram_din, e_csn0, e_csn1, e_wen, e_addr, e_ben, e_din); end
            checks++; if ({if_rvalid, ls_rvalid, ext_rvalid} !== {m_pend == W_IF && !cpurst, m_pend == W_LS && !cpurst, m_pend == W_EXT && !cpurst}) begin
                errors++; $display("FAIL rand%0d_rvalid: got %b pend=%0d rst=%b", n, {if_rvalid, ls_rvalid, ext_rvalid}, m_pend, cpurst); end
            if (!cpurst && m_pend == W_IF) begin
                checks++; if (if_rdata !== sram_dout) begin
                    errors++; $display("FAIL rand%0d_if_rdata: got %h want %h", n, if_rdata, sram_dout); end
            end
            if (!cpurst && m_pend == W_LS) begin
                checks++; if (ls_rdata !== (m_half ? sram_dout[63:32] : sram_dout[31:0])) begin
                    errors++; $display("FAIL rand%0d_ls_rdata: got %h half=%b dout=%h", n, ls_rdata, m_half, sram_dout); end
            end
            if (!cpurst && m_pend == W_EXT) begin
                checks++; if (ext_rdata !== (m_half ? sram_dout[63:32] : sram_dout[31:0])) begin
                    errors++; $display("FAIL rand%0d_ext_rdata: got %h half=%b dout=%h", n, ext_rdata, m_half, sram_dout); end
            end
            if (!EXT_EN) begin
                checks++; if (ext_rdata !== 32'h0) begin
                    errors++; $display("FAIL rand%0d_ext_tied: got %h want 0", n, ext_rdata); end
            end
            hold_if = if_req && (w != W_IF) && !cpurst;
            tick();
        end
        cpurst = 0; idle_inputs(); #1; tick();
    endtask

    initial begin
        cpurst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_ls_write();
        test_conflict();
        test_starvation();
        test_ext_read();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
